irq_controller: RTL

- Parametrised N-channel interrupt controller; successor to the fixed two-source (TIMER1 overflow / INT1) latch pair inside the control unit.
- Per-channel edge/level mode, maskable pending latches, fixed priority arbitration, vectored request with CPU ACK/EOI handshake.
- Sits between timers/external pins and the control unit. The control unit uses INT_VECTOR as its jump target.

---
 rtl/irq_controller.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/irq_controller.sv
// irq_controller: N-channel vectored interrupt controller.
//
// Each channel is either rising-edge triggered or level triggered. A pending
// bit is captured per channel, qualified by a mask register and a global
// enable, and the lowest-numbered eligible channel is offered to the CPU.
// The CPU accepts with INT_ACK and ends the handler with INT_EOI. There is no
// nesting: while a handler runs, no new interrupt is offered, but pending
// bits keep accumulating.
//
// Ports:
//   CLK          system clock, rising edge
//   CPU_Reset_n  asynchronous active-low reset
//   IRQ_IN       raw interrupt sources, synchronous to CLK
//   GIE          global interrupt enable
//   MASK_WE      load MASK from MASK_DATA at the next edge
//   MASK_DATA    new mask value (1 = channel enabled)
//   PEND_CLR     one-cycle software clear of edge-channel pending bits
//   INT_ACK      CPU accepts the offered interrupt (one-cycle pulse)
//   INT_EOI      CPU end-of-interrupt (one-cycle pulse)
//   INT_REQ      interrupt offered to the CPU
//   INT_ID       channel being offered or serviced
//   INT_VECTOR   handler address: VECTOR_BASE + INT_ID*VECTOR_STRIDE
//   PENDING      pending register
//   MASK         mask register
//   IN_SERVICE   a handler is currently running

module irq_controller #(
    parameter int unsigned     N_CH          = 4,
    parameter int unsigned     ID_W          = 2,
    parameter logic [N_CH-1:0] EDGE_MODE     = {N_CH{1'b1}},
    parameter logic [N_CH-1:0] MASK_RESET    = {N_CH{1'b0}},
    parameter logic [15:0]     VECTOR_BASE   = 16'h0010,
    parameter logic [15:0]     VECTOR_STRIDE = 16'h0008
) (
    input  logic            CLK,
    input  logic            CPU_Reset_n,
    input  logic [N_CH-1:0] IRQ_IN,
    input  logic            GIE,
    input  logic            MASK_WE,
    input  logic [N_CH-1:0] MASK_DATA,
    input  logic [N_CH-1:0] PEND_CLR,
    input  logic            INT_ACK,
    input  logic            INT_EOI,
    output logic            INT_REQ,
    output logic [ID_W-1:0] INT_ID,
    output logic [15:0]     INT_VECTOR,
    output logic [N_CH-1:0] PENDING,
    output logic [N_CH-1:0] MASK,
    output logic            IN_SERVICE
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OFFER   = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [N_CH-1:0] irq_prev;
    logic [N_CH-1:0] eligible;
    logic [N_CH-1:0] id_onehot;
    logic [N_CH-1:0] edge_set;
    logic [N_CH-1:0] edge_clr;
    logic [N_CH-1:0] pending_nxt;
    logic [ID_W-1:0] winner;
    logic            any_eligible;
    logic            offered_eligible;
    logic            ack_take;
    logic            latch_id;

    // Eligible channels: pending, unmasked, and globally enabled.
    assign eligible     = GIE ? (PENDING & MASK) : '0;
    assign any_eligible = |eligible;

    // Fixed priority: lowest set index wins.
    always_comb begin
        winner = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = ID_W'(i);
            end
        end
    end

    // One-hot decode of INT_ID; avoids indexing a vector with a mismatched width.
    always_comb begin
        id_onehot = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            id_onehot[i] = (INT_ID == ID_W'(i));
        end
    end

    assign offered_eligible = |(eligible & id_onehot);

    // State register.
    always_ff @(posedge CLK or negedge CPU_Reset_n) begin
        if (!CPU_Reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. ACK beats withdrawal when both happen in OFFER.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (any_eligible) begin
                    state_nxt = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (INT_ACK) begin
                    state_nxt = ST_SERVICE;
                end else if (!offered_eligible) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (INT_EOI) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode; INT_REQ and IN_SERVICE come straight from the state register.
    always_comb begin
        INT_REQ    = 1'b0;
        IN_SERVICE = 1'b0;
        ack_take   = 1'b0;
        latch_id   = 1'b0;
        case (state)
            ST_IDLE: begin
                latch_id = any_eligible;
            end
            ST_OFFER: begin
                INT_REQ  = 1'b1;
                ack_take = INT_ACK;
            end
            ST_SERVICE: begin
                IN_SERVICE = 1'b1;
            end
            default: begin
                INT_REQ = 1'b0;
            end
        endcase
    end

    // Edge channels: a rising edge sets, PEND_CLR or ACK of this channel clears,
    // and a set in the same cycle as a clear wins. Level channels track the input.
    assign edge_set    = IRQ_IN & ~irq_prev;
    assign edge_clr    = PEND_CLR | (ack_take ? id_onehot : '0);
    assign pending_nxt = (EDGE_MODE & (edge_set | (PENDING & ~edge_clr)))
                       | (~EDGE_MODE & IRQ_IN);

    // Pending, mask and edge-history registers.
    always_ff @(posedge CLK or negedge CPU_Reset_n) begin
        if (!CPU_Reset_n) begin
            PENDING  <= '0;
            MASK     <= MASK_RESET;
            irq_prev <= '0;
        end else begin
            PENDING  <= pending_nxt;
            irq_prev <= IRQ_IN;
            if (MASK_WE) begin
                MASK <= MASK_DATA;
            end
        end
    end

    // INT_ID is captured on entry to OFFER and held through SERVICE.
    always_ff @(posedge CLK or negedge CPU_Reset_n) begin
        if (!CPU_Reset_n) begin
            INT_ID <= '0;
        end else if (latch_id) begin
            INT_ID <= winner;
        end
    end

    // Handler address, truncated to 16 bits.
    assign INT_VECTOR = 16'(32'(VECTOR_BASE) + 32'(INT_ID) * 32'(VECTOR_STRIDE));

endmodule
